rename_regfile: RTL

Parametrised architectural register file with per-register rename state (busy bit and ROB tag) for the out-of-order core. It has two combinational read ports with same-cycle commit bypass, one issue (rename) port and one commit (write-back) port. A flush port supports misprediction recovery. It sits between decode/issue, the reservation stations and the ROB commit stage.

---
 rtl/rename_regfile_if.sv | 59 +++++
 rtl/rename_regfile.sv | 102 ++++++++++
 2 files changed

// File: rtl/rename_regfile_if.sv
// Bundles the issue, commit, read and status signals of rename_regfile.
// RENAME_RF_DBG_PORT_EN adds a debug read of committed data.
interface rename_regfile_if #(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int TAG_W = 4
);
   localparam int AW = $clog2(NREG);
   localparam int CW = $clog2(NREG + 1);

   logic             rdy_in;
   logic             flush_in;
   logic             iss_en_in;
   logic [AW-1:0]    iss_rd_in;
   logic [TAG_W-1:0] iss_tag_in;
   logic             cmt_en_in;
   logic [AW-1:0]    cmt_rd_in;
   logic [TAG_W-1:0] cmt_tag_in;
   logic [XLEN-1:0]  cmt_data_in;
   logic [AW-1:0]    rs1_addr_in;
   logic [XLEN-1:0]  rs1_data_out;
   logic             rs1_busy_out;
   logic [TAG_W-1:0] rs1_tag_out;
   logic [AW-1:0]    rs2_addr_in;
   logic [XLEN-1:0]  rs2_data_out;
   logic             rs2_busy_out;
   logic [TAG_W-1:0] rs2_tag_out;
   logic [CW-1:0]    busy_cnt_out;
`ifdef RENAME_RF_DBG_PORT_EN
   logic [AW-1:0]    dbg_addr_in;
   logic [XLEN-1:0]  dbg_data_out;
`endif

   modport master (
      output rdy_in, flush_in, iss_en_in, iss_rd_in, iss_tag_in,
      output cmt_en_in, cmt_rd_in, cmt_tag_in, cmt_data_in,
      output rs1_addr_in, rs2_addr_in,
      input  rs1_data_out, rs1_busy_out, rs1_tag_out,
      input  rs2_data_out, rs2_busy_out, rs2_tag_out,
      input  busy_cnt_out
`ifdef RENAME_RF_DBG_PORT_EN
      , output dbg_addr_in
      , input  dbg_data_out
`endif
   );

   modport slave (
      input  rdy_in, flush_in, iss_en_in, iss_rd_in, iss_tag_in,
      input  cmt_en_in, cmt_rd_in, cmt_tag_in, cmt_data_in,
      input  rs1_addr_in, rs2_addr_in,
      output rs1_data_out, rs1_busy_out, rs1_tag_out,
      output rs2_data_out, rs2_busy_out, rs2_tag_out,
      output busy_cnt_out
`ifdef RENAME_RF_DBG_PORT_EN
      , input  dbg_addr_in
      , output dbg_data_out
`endif
   );
endinterface

// File: rtl/rename_regfile.sv
// Architectural register file with per-register busy/ROB-tag rename state,
// commit bypass on both read ports and flush recovery. Optional: RENAME_RF_DBG_PORT_EN.
module rename_regfile #(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int TAG_W = 4
) (
   input logic             clk_in,
   input logic             rst_in,
   rename_regfile_if.slave rf
);
   localparam int AW = $clog2(NREG);
   localparam int CW = $clog2(NREG + 1);

   logic [XLEN-1:0]  data_q [NREG];
   logic [TAG_W-1:0] tag_q  [NREG];
   logic [NREG-1:0]  busy_q;
   logic [CW-1:0]    busy_cnt_q;

   logic             cmt_wr;
   logic             cmt_match;
   logic             iss_wr;
   logic             cnt_inc;
   logic             cnt_dec;
   logic [CW-1:0]    cnt_next;

   // A commit only retires the rename if it comes from the latest producer.
   always_comb begin
      cmt_wr    = rf.cmt_en_in && (rf.cmt_rd_in != '0);
      cmt_match = cmt_wr && busy_q[rf.cmt_rd_in] && (tag_q[rf.cmt_rd_in] == rf.cmt_tag_in);
      iss_wr    = rf.iss_en_in && (rf.iss_rd_in != '0) && !rf.flush_in;
      cnt_inc   = iss_wr && !busy_q[rf.iss_rd_in];
      cnt_dec   = cmt_match && !(iss_wr && (rf.iss_rd_in == rf.cmt_rd_in));
      if (rf.flush_in)
         cnt_next = '0;
      else
         cnt_next = busy_cnt_q + CW'(cnt_inc) - CW'(cnt_dec);
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < NREG; i++) begin
            data_q[i] <= '0;
            tag_q[i]  <= '0;
         end
         busy_q     <= '0;
         busy_cnt_q <= '0;
      end else if (rf.rdy_in) begin
         if (cmt_wr)
            data_q[rf.cmt_rd_in] <= rf.cmt_data_in;
         if (rf.flush_in) begin
            busy_q <= '0;
            for (int i = 0; i < NREG; i++)
               tag_q[i] <= '0;
         end else begin
            if (cmt_match)
               busy_q[rf.cmt_rd_in] <= 1'b0;
            // Placed after the commit clear so a same-register issue wins.
            if (iss_wr) begin
               busy_q[rf.iss_rd_in] <= 1'b1;
               tag_q[rf.iss_rd_in]  <= rf.iss_tag_in;
            end
         end
         busy_cnt_q <= cnt_next;
      end
   end

   logic [AW-1:0]    rd_addr [2];
   logic [XLEN-1:0]  rd_data [2];
   logic             rd_busy [2];
   logic [TAG_W-1:0] rd_tag  [2];

   assign rd_addr[0] = rf.rs1_addr_in;
   assign rd_addr[1] = rf.rs2_addr_in;

   // Reads see pre-issue state; a matching commit in flight is forwarded.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = data_q[rd_addr[p]];
         rd_busy[p] = busy_q[rd_addr[p]];
         rd_tag[p]  = busy_q[rd_addr[p]] ? tag_q[rd_addr[p]] : '0;
         if (rf.rdy_in && rf.cmt_en_in && (rd_addr[p] != '0) && busy_q[rd_addr[p]] &&
             (tag_q[rd_addr[p]] == rf.cmt_tag_in) && (rf.cmt_rd_in == rd_addr[p])) begin
            rd_data[p] = rf.cmt_data_in;
            rd_busy[p] = 1'b0;
            rd_tag[p]  = '0;
         end
      end
   end

   assign rf.rs1_data_out = rd_data[0];
   assign rf.rs1_busy_out = rd_busy[0];
   assign rf.rs1_tag_out  = rd_tag[0];
   assign rf.rs2_data_out = rd_data[1];
   assign rf.rs2_busy_out = rd_busy[1];
   assign rf.rs2_tag_out  = rd_tag[1];
   assign rf.busy_cnt_out = busy_cnt_q;

`ifdef RENAME_RF_DBG_PORT_EN
   assign rf.dbg_data_out = data_q[rf.dbg_addr_in];
`endif
endmodule
